// File: rtl/ram_pkg.sv
// ram_pkg: shared defaults and FSM state encoding for the handshake RAM responder.
package ram_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;
  localparam int DEPTH_DEF = 1 << AW_DEF;
  typedef enum logic [2:0] {CLEAR, IDLE, ACCESS, ACK, WAIT_REL} state_t;
endpackage

// File: rtl/ram_core.sv
// ram_core: single-port storage with synchronous write and registered read, no reset.
module ram_core #(
  parameter int AW = 10,
  parameter int DW = 8,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/ram_hs_responder.sv
// ram_hs_responder: clears the RAM after reset, then serves sel/ack handshaked reads and writes.
module ram_hs_responder import ram_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          write,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          ack,
  output logic          ready
);
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, addr_q, addr_d, ram_addr;
  logic [DW-1:0] din_q, din_d, dout_q, dout_d, ram_wdata, rdata;
  logic wr_q, wr_d, ack_q, ack_d, ready_q, ready_d, ram_we;
  // Clear path owns the RAM port during CLEAR, the captured request otherwise.
  assign ram_we = state_q == CLEAR || (state_q == ACCESS && wr_q);
  assign ram_addr = state_q == CLEAR ? cnt_q : addr_q;
  assign ram_wdata = state_q == CLEAR ? '0 : din_q;
  ram_core #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_core (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    addr_d = addr_q;
    din_d = din_q;
    dout_d = dout_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      IDLE: begin
        if (sel) begin
          state_d = ACCESS;
          wr_d = write;
          addr_d = address;
          din_d = data_in;
        end
      end
      ACCESS: state_d = ACK;
      // The registered read issued in ACCESS lands here, alongside ack.
      ACK: begin
        state_d = WAIT_REL;
        dout_d = wr_q ? dout_q : rdata;
      end
      WAIT_REL: state_d = sel ? WAIT_REL : IDLE;
      default: state_d = CLEAR;
    endcase
    ack_d = state_q == ACK;
    ready_d = state_d != CLEAR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      dout_q <= '0;
      ack_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      din_q <= din_d;
      dout_q <= dout_d;
      ack_q <= ack_d;
      ready_q <= ready_d;
    end
  end
  assign data_out = dout_q;
  assign ack = ack_q;
  assign ready = ready_q;
endmodule

// File: tb/tb_ram_hs_responder.sv
// tb_ram_hs_responder: directed and random handshake traffic checked against an array model.
module tb_ram_hs_responder;
  logic clk = 1'b0, rst, sel, write;
  logic [9:0] address;
  logic [7:0] data_in, data_out;
  logic ack, ready;
  int checks = 0, failures = 0;
  logic [7:0] mdl [1024];
  logic [7:0] mdout;

  ram_hs_responder dut (
    .clk(clk), .rst(rst), .sel(sel), .write(write), .address(address),
    .data_in(data_in), .data_out(data_out), .ack(ack), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
    mdout = 8'h00;
  endtask

  task automatic wait_ready(output int n, output logic ak);
    n = 0;
    ak = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (ack) ak = 1'b1;
    end while (!ready && n < 1100);
  endtask

  // One full handshake: drive, expect ack on the third falling edge, drop sel.
  task automatic req(input logic wr, input logic [9:0] a, input logic [7:0] d);
    int n;
    n = 0;
    write = wr;
    address = a;
    data_in = d;
    sel = 1'b1;
    do begin
      @(negedge clk);
      n++;
      write = 1'($urandom);
      address = 10'($urandom);
      data_in = 8'($urandom);
    end while (!ack && n < 10);
    chk("ack_latency", n, 3);
    if (wr) mdl[a] = d;
    else mdout = mdl[a];
    chk(wr ? "write_dout_hold" : "read_data", data_out, mdout);
    sel = 1'b0;
    @(negedge clk);
    chk("ack_single_cycle", ack, 0);
  endtask

  initial begin
    int n;
    logic ak;
    logic [9:0] a;
    logic [7:0] d;
    rst = 1'b1;
    sel = 1'b0;
    write = 1'b0;
    address = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_ack", ack, 0);
    chk("rst_dout", data_out, 0);
    rst = 1'b0;
    wait_ready(n, ak);
    chk("clear_len", n, 1024);
    chk("clear_ack", ak, 0);
    model_clear();
    req(1'b0, 10'd5, 8'h00);
    req(1'b1, 10'd1023, 8'hFE);
    req(1'b0, 10'd1023, 8'h00);
    for (int k = 0; k < 1024; k++) req(1'b1, 10'(k), 8'((2 * k) % 256));
    void'($urandom(35));
    repeat (20) req(1'b0, 10'($urandom_range(1023)), 8'h00);
    repeat (30) begin
      a = 10'($urandom);
      d = 8'($urandom);
      req(1'($urandom), a, d);
    end
    // sel held long after ack must not start a second access
    write = 1'b1;
    address = 10'd20;
    data_in = 8'h5A;
    sel = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 10);
    chk("hold_latency", n, 3);
    mdl[20] = 8'h5A;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack) n++;
    end
    chk("hold_extra_acks", n, 0);
    sel = 1'b0;
    @(negedge clk);
    req(1'b0, 10'd20, 8'h00);
    // request raised during CLEAR waits for the first IDLE edge
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_dout", data_out, 0);
    write = 1'b1;
    address = 10'd7;
    data_in = 8'h55;
    sel = 1'b1;
    rst = 1'b0;
    wait_ready(n, ak);
    chk("clear2_len", n, 1024);
    chk("clear2_ack", ak, 0);
    model_clear();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 10);
    chk("clear_req_latency", n, 3);
    chk("clear_req_dout", data_out, 0);
    mdl[7] = 8'h55;
    sel = 1'b0;
    @(negedge clk);
    req(1'b0, 10'd7, 8'h00);
    req(1'b0, 10'd8, 8'h00);
    // reset in the middle of a write aborts it and wipes memory
    req(1'b1, 10'd3, 8'hAA);
    write = 1'b1;
    address = 10'd9;
    data_in = 8'h33;
    sel = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ready", ready, 0);
    chk("abort_ack", ack, 0);
    chk("abort_dout", data_out, 0);
    @(negedge clk);
    sel = 1'b0;
    rst = 1'b0;
    wait_ready(n, ak);
    chk("clear3_len", n, 1024);
    chk("clear3_ack", ak, 0);
    model_clear();
    req(1'b0, 10'd3, 8'h00);
    req(1'b0, 10'd9, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
